// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line front end.
// PS2_TX_RETRY_EN (in ps2_host_tx) enables automatic retry; the retry constants here serve it.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int FRAME_BITS = 10;
    localparam int IDX_W      = 4;
    localparam int PH_W       = 16;   // inhibit/start phase counter
    localparam int TO_W       = 20;   // covers the 20 ms timeout at 50 MHz
    localparam int RETRY_W    = 2;
    localparam int MAX_RETRY  = 2;

    // Frame is sent LSB first: data[7:0], odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge strobe
// on the synchronized clock. Flops reset to 1 (idle line level).
module ps2_sync_edge (
    input  logic sys_clk,
    input  logic clr,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic clk_m, data_m, clk_prev;

    always_ff @(posedge sys_clk or posedge clr) begin
        if (clr) begin
            clk_m    <= 1'b1;
            clk_s    <= 1'b1;
            clk_prev <= 1'b1;
            data_m   <= 1'b1;
            data_s   <= 1'b1;
        end else begin
            clk_m    <= clk_raw;
            clk_s    <= clk_m;
            clk_prev <= clk_s;
            data_m   <= data_raw;
            data_s   <= data_m;
        end
    end

    assign fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, device-clocked frame, ACK).
// Define PS2_TX_RETRY_EN to retry NACKed/timed-out frames up to MAX_RETRY times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int START_CYC   = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               sys_clk,
    input  logic               clr,
    input  logic               wr,
    input  logic [7:0]         wdata,
    output logic               busy,
    output logic               done,
    output logic               ack_ok,
    output logic               err,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe
`ifdef PS2_TX_RETRY_EN
   ,output logic [RETRY_W-1:0] retries
`endif
);

    ps2_state_e            state, state_d;
    logic [PH_W-1:0]       cnt, cnt_d;
    logic [TO_W-1:0]       to_cnt, to_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [FRAME_BITS-1:0] frame, frame_d;
    logic                  busy_d, done_d, ack_d, err_d, clk_oe_d, data_oe_d;
    logic                  timeout, to_fail, nack_fail;
    logic                  clk_s, data_s, fall;
`ifdef PS2_TX_RETRY_EN
    logic [RETRY_W-1:0]    retries_d;
`endif

    ps2_sync_edge u_sync (
        .sys_clk  (sys_clk),
        .clr      (clr),
        .clk_raw  (ps2_clk_in),
        .data_raw (ps2_data_in),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        to_d      = to_cnt;
        idx_d     = idx;
        frame_d   = frame;
        busy_d    = busy;
        done_d    = 1'b0;
        ack_d     = ack_ok;
        err_d     = err;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        to_fail   = 1'b0;
        nack_fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retries_d = retries;
`endif
        case (state)
            IDLE: begin
                // Holding off while done is high keeps accept and done in separate cycles.
                if (wr && !done) begin
                    frame_d   = make_frame(wdata);
                    ack_d     = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retries_d = '0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt == PH_W'(INHIBIT_CYC - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt + PH_W'(1);
                end
            end
            START: begin
                if (cnt == PH_W'(START_CYC - 1)) begin
                    clk_oe_d = 1'b0;
                    to_d     = '0;
                    idx_d    = '0;
                    state_d  = SEND;
                end else begin
                    cnt_d = cnt + PH_W'(1);
                end
            end
            SEND: begin
                if (timeout) begin
                    to_fail = 1'b1;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                    if (fall) begin
                        data_oe_d = ~frame[idx];
                        if (idx == IDX_W'(FRAME_BITS - 1)) state_d = ACK;
                        else                               idx_d   = idx + IDX_W'(1);
                    end
                end
            end
            ACK: begin
                data_oe_d = 1'b0;
                if (timeout) begin
                    to_fail = 1'b1;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                    if (fall) begin
                        if (!data_s) begin
                            ack_d   = 1'b1;
                            state_d = WAIT_IDLE;
                        end else begin
                            nack_fail = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    to_fail = 1'b1;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                    if (clk_s && data_s) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_fail || nack_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retries < RETRY_W'(MAX_RETRY)) begin
                retries_d = retries + RETRY_W'(1);
                ack_d     = 1'b0;
                err_d     = 1'b0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = INHIBIT;
            end else
`endif
            if (to_fail) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                err_d     = 1'b1;
                ack_d     = 1'b0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end else begin
                err_d   = 1'b1;
                state_d = WAIT_IDLE;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            to_cnt      <= '0;
            idx         <= '0;
            frame       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retries     <= '0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            to_cnt      <= to_d;
            idx         <= idx_d;
            frame       <= frame_d;
            busy        <= busy_d;
            done        <= done_d;
            ack_ok      <= ack_d;
            err         <= err_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
            retries     <= retries_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device-side PS/2 model, frame/outcome model and
// a per-cycle monitor of the request sequence, busy/done and completion status.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int STC  = 4;
    localparam int TMO  = 3000;
    localparam int HALF = 25;

    logic sys_clk = 1'b0;
    logic clr = 1'b1;
    logic wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic busy, done, ack_ok, err, ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .START_CYC(STC), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk     (sys_clk),
        .clr         (clr),
        .wr          (wr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int started = 0, finished = 0, aborted = 0;
    int acc_cyc = 0;
    int exp_out = 0;   // 0 = ACK, 1 = NACK, 2 = timeout
    int mon_k;
    logic in_txn;
    assign in_txn = (started != finished + aborted);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected 10-bit frame: data LSB first, parity makes total ones odd, stop = 1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, logic'((ones % 2) == 0), b};
    endfunction

    // Monitor: request waveform after accept, busy while in flight, outcome at done.
    always @(negedge sys_clk) begin
        if (!clr) begin
            if (in_txn) begin
                mon_k = cyc - acc_cyc;
                if (mon_k >= 0 && mon_k <= INH + STC) begin
                    check("clk_oe_request", 32'(ps2_clk_oe), 32'(mon_k < INH + STC));
                    check("data_oe_request", 32'(ps2_data_oe), 32'(mon_k >= INH));
                end
                if (done) begin
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("ack_ok_at_done", 32'(ack_ok), 32'(exp_out == 0));
                    check("err_at_done", 32'(err), 32'(exp_out != 0));
                    check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                    if (exp_out == 2) check("timeout_latency", 32'(mon_k), 32'(INH + STC + TMO));
                    finished++;
                end else if (mon_k >= 0) begin
                    check("busy_in_flight", 32'(busy), 32'd1);
                end
            end else begin
                check("idle_no_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int outcome);
        @(negedge sys_clk);
        wr = 1'b1;
        wdata = b;
        acc_cyc = cyc + 1;
        exp_out = outcome;
        started++;
        @(negedge sys_clk);
        wr = 1'b0;
    endtask

    // Device: detect request, clock 10 bits (sampling at rising edges), then ACK/NACK.
    // seen[0] = start bit on the line at request time, seen[10:1] = frame bits.
    task automatic dev_run(input bit nack, input int abort_at, output logic [10:0] seen);
        int t;
        seen = '1;
        t = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_in == 1'b0) && t < 400) begin
            @(negedge sys_clk);
            t++;
        end
        check("device_saw_request", 32'(t < 400), 32'd1);
        if (t >= 400) return;
        seen[0] = ps2_data_in;
        repeat (HALF) @(negedge sys_clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            if (i == abort_at) return;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            seen[i] = ps2_data_in;
        end
        dev_data_low = !nack;
        repeat (HALF) @(negedge sys_clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (in_txn && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check("transaction_completed", 32'(in_txn), 32'd0);
    endtask

    logic [10:0] seen;
    logic [7:0]  rb;
    bit          rn;

    initial begin
        clr = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_ok", 32'(ack_ok), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        clr = 1'b0;
        repeat (3) @(negedge sys_clk);

        // 0xED ACKed, with a second wr (0x55) while busy that must be ignored.
        fork
            begin
                send(8'hED, 0);
                repeat (5) @(negedge sys_clk);
                wr = 1'b1;
                wdata = 8'h55;
                @(negedge sys_clk);
                wr = 1'b0;
            end
            dev_run(1'b0, 0, seen);
        join
        wait_done(60);
        check("frame_ED_literal", 32'(seen), 32'(11'b111_1101_1010));
        check("frame_ED_model", 32'(seen), 32'({model_frame(8'hED), 1'b0}));
        @(negedge sys_clk);
        check("ED_ack_ok_after", 32'(ack_ok), 32'd1);
        check("ED_err_after", 32'(err), 32'd0);
        check("ED_busy_after", 32'(busy), 32'd0);

        // Parity boundaries.
        fork send(8'h01, 0); dev_run(1'b0, 0, seen); join
        wait_done(60);
        check("parity_01", 32'(seen[9]), 32'd0);
        check("frame_01_model", 32'(seen), 32'({model_frame(8'h01), 1'b0}));
        fork send(8'hFF, 0); dev_run(1'b0, 0, seen); join
        wait_done(60);
        check("parity_FF", 32'(seen[9]), 32'd1);
        check("ack_ok_FF", 32'(ack_ok), 32'd1);

        // NACK.
        fork send(8'hF4, 1); dev_run(1'b1, 0, seen); join
        wait_done(60);
        check("frame_F4_model", 32'(seen), 32'({model_frame(8'hF4), 1'b0}));
        check("nack_err", 32'(err), 32'd1);
        check("nack_ack_ok", 32'(ack_ok), 32'd0);

        // Random bytes, random ACK/NACK.
        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            fork send(rb, int'(rn)); dev_run(rn, 0, seen); join
            wait_done(60);
            check("random_frame", 32'(seen), 32'({model_frame(rb), 1'b0}));
        end

        // Device never clocks: timeout.
        send(8'hA5, 2);
        wait_done(INH + STC + TMO + 100);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_clk_line", 32'(ps2_clk_in), 32'd1);
        check("timeout_data_line", 32'(ps2_data_in), 32'd1);

        // Asynchronous clear in SEND after 4 device falls (idx = 4).
        fork send(8'hED, 0); dev_run(1'b0, 4, seen); join
        check("pre_clr_busy", 32'(busy), 32'd1);
        #3;
        clr = 1'b1;
        aborted++;
        #1;
        check("clr_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("clr_data_oe", 32'(ps2_data_oe), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge sys_clk);
        clr = 1'b0;
        repeat (3) @(negedge sys_clk);
        fork send(8'hFF, 0); dev_run(1'b0, 0, seen); join
        wait_done(60);
        check("after_clr_frame", 32'(seen), 32'({model_frame(8'hFF), 1'b0}));
        check("after_clr_ack", 32'(ack_ok), 32'd1);

        repeat (5) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
